// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_WIDTH data bits LSB first, optional parity, one or two stops.
// One serial bit per CLK edge; TX_OUT and BUSY come straight from flops.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line at IDLE_LEVEL, ready to accept a word
// S_START  | start bit (~IDLE_LEVEL) on the line
// S_DATA   | data bit bit_cnt on the line, LSB first
// S_PARITY | parity over captured word, inverted for odd parity
// S_STOP1  | first stop bit; final cycle of the frame when one stop bit is used
// S_STOP2  | second stop bit, always the final cycle of its frame
module uart_tx_frame #(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  generate
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
      $error("uart_tx_frame: DATA_WIDTH must be in 5..9");
    end
  endgenerate

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   shift;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    stop2_q;
  logic                    final_cyc;

  // The last stop cycle behaves like idle so back-to-back frames have no gap.
  assign final_cyc = (state == S_IDLE) || (state == S_STOP2) ||
                     ((state == S_STOP1) && !stop2_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      TX_OUT    <= IDLE_LEVEL;
      BUSY      <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (final_cyc) begin
      if (DATA_VALID && !BUSY) begin
        state     <= S_START;
        TX_OUT    <= ~IDLE_LEVEL;
        BUSY      <= 1'b1;
        shift     <= P_DATA;
        bit_cnt   <= '0;
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
        stop2_q   <= STOP2;
      end else begin
        state  <= S_IDLE;
        TX_OUT <= IDLE_LEVEL;
        BUSY   <= 1'b0;
      end
    end else begin
      case (state)
        S_START: begin
          state   <= S_DATA;
          TX_OUT  <= shift[0];
          shift   <= shift >> 1;
          bit_cnt <= '0;
        end
        S_DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (par_en_q) begin
              state  <= S_PARITY;
              TX_OUT <= par_bit_q;
            end else begin
              state  <= S_STOP1;
              TX_OUT <= IDLE_LEVEL;
              BUSY   <= stop2_q;
            end
          end else begin
            TX_OUT  <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          state  <= S_STOP1;
          TX_OUT <= IDLE_LEVEL;
          BUSY   <= stop2_q;
        end
        S_STOP1: begin
          state  <= S_STOP2;
          TX_OUT <= IDLE_LEVEL;
          BUSY   <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          TX_OUT <= IDLE_LEVEL;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: frame-level reference model feeds a queue of expected
// {tx, busy} per cycle; a monitor pops one entry per cycle and compares.
module tb_uart_tx_frame;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] P_DATA = '0;
  logic         DATA_VALID = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         STOP2 = 1'b0;
  logic         TX_OUT;
  logic         BUSY;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  uart_tx_frame #(.DATA_WIDTH(W), .IDLE_LEVEL(1'b1)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(TX_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic tx, input logic busy,
                       input logic etx, input logic ebusy);
    checks++;
    if (tx !== etx || busy !== ebusy) begin
      errors++;
      $display("FAIL %s @%0t: got tx=%b busy=%b, expected tx=%b busy=%b",
               name, $time, tx, busy, etx, ebusy);
    end
  endtask

  // Whole frame as the line should show it, one {tx, busy} entry per cycle.
  function automatic void push_frame(logic [W-1:0] d, logic pe, logic pt, logic s2);
    exp_q.push_back(2'b01);
    for (int i = 0; i < W; i++) exp_q.push_back({d[i], 1'b1});
    if (pe) exp_q.push_back({(^d) ^ pt, 1'b1});
    if (s2) exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
  endfunction

  // An empty queue means the line is idle or in its final stop cycle: a request is taken.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic pe,
                       input logic pt, input logic s2, output logic acc);
    @(negedge CLK);
    DATA_VALID = v;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    STOP2      = s2;
    acc = v && RST && (exp_q.size() == 0);
    if (acc) push_frame(d, pe, pt, s2);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, P_DATA, PAR_EN, PAR_TYP, STOP2, acc);
  endtask

  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt, input logic s2);
    logic acc;
    drive(1'b1, d, pe, pt, s2, acc);
  endtask

  initial begin
    logic [1:0] e;
    forever begin
      @(posedge CLK);
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b10;
      check("line", TX_OUT, BUSY, e[1], e[0]);
    end
  end

  initial begin
    logic acc;
    int   n;
    #12;
    check("reset_state", TX_OUT, BUSY, 1'b1, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    idle(2);

    send(8'hA5, 1'b0, 1'b0, 1'b0); idle(12);
    send(8'hA5, 1'b1, 1'b0, 1'b0); idle(12);
    send(8'hA5, 1'b1, 1'b1, 1'b0); idle(12);
    send(8'h01, 1'b1, 1'b0, 1'b0); idle(12);
    send(8'hFF, 1'b1, 1'b0, 1'b1); idle(14);

    // back-to-back: request held high until the second word is taken
    drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, acc);
    n = 0;
    do begin
      drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, acc);
      n++;
    end while (!acc && n < 20);
    idle(12);

    // inputs wiggle and extra requests during a frame must be ignored
    send(8'h55, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive((i % 2) == 0, 8'hAA, 1'b1, 1'b1, 1'b1, acc);
    idle(12);

    // asynchronous reset in the 4th data bit
    send(8'h0F, 1'b0, 1'b0, 1'b0);
    idle(4);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check("async_reset", TX_OUT, BUSY, 1'b1, 1'b0);
    exp_q.delete();
    idle(3);
    @(negedge CLK);
    RST = 1'b1;
    idle(4);
    send(8'h81, 1'b0, 1'b0, 1'b0); idle(12);

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1) == 1, W'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), acc);
    idle(16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmit framer. It integrates the serializer, parity generator, frame state machine and line-driver mux into one registered block. It accepts a parallel word on a valid strobe and shifts out start, data (LSB first), optional parity and one or two stop bits, at one bit per CLK cycle. CLK is the baud-rate tick clock. The block sits between the TX data source (FIFO or register interface) and the TX pin.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal 5..9)
IDLE_LEVEL, 1, line level in idle and stop bits; start bit is its complement

Ports:
CLK  input  1  bit clock, one serial bit per rising edge
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel word to transmit
DATA_VALID  input  1  request to send P_DATA; sampled on rising edge
PAR_EN  input  1  1 = insert parity bit after data
PAR_TYP  input  1  0 = even parity, 1 = odd parity
STOP2  input  1  1 = two stop bits, 0 = one
TX_OUT  output  1  serial line, registered
BUSY  output  1  high while a frame is in progress and a new request is not accepted

Behaviour:
- Clocking and reset: one clock (CLK); reset RST is asynchronous and active-low.
- Reset values while RST=0: state IDLE, TX_OUT=IDLE_LEVEL, BUSY=0, shift register and bit counter cleared.
- Reset asserted mid-frame aborts the frame immediately, without waiting for CLK. The line returns to IDLE_LEVEL, and no partial frame resumes after release.
- Acceptance: a word is accepted on a rising edge where DATA_VALID=1 and BUSY=0.
- On acceptance, P_DATA, PAR_EN, PAR_TYP and STOP2 are captured. Later changes to these inputs do not affect the frame in flight.
- DATA_VALID while BUSY=1 is ignored; it is neither queued nor acknowledged.
- Latency: the start bit is driven on TX_OUT from the acceptance edge. It is held for exactly one cycle, and each following bit is also held for one cycle.
- States:
  - IDLE: TX_OUT=IDLE_LEVEL, BUSY=0. On acceptance -> START.
  - START: TX_OUT=~IDLE_LEVEL, BUSY=1. -> DATA.
  - DATA: TX_OUT=shift[0], bit 0 first. The counter runs 0..DATA_WIDTH-1. After the last bit -> PARITY if PAR_EN captured, else STOP1.
  - PARITY: TX_OUT = (XOR of captured data) XOR PAR_TYP. -> STOP1.
  - STOP1: TX_OUT=IDLE_LEVEL. -> STOP2 state if STOP2 captured, else END.
  - STOP2: TX_OUT=IDLE_LEVEL. -> END.
  - END is not a separate state. The final stop-bit cycle behaves like IDLE for acceptance.
- BUSY timing: BUSY=0 during the final stop-bit cycle.
  - If DATA_VALID=1 on that edge, the next START follows with zero idle gap.
  - Otherwise the block goes to IDLE.
- Frame length in cycles: 2 + DATA_WIDTH + PAR_EN + STOP2.
- Parity is computed over exactly DATA_WIDTH captured bits. The parity bit is never counted in BUSY-low timing.
- TX_OUT is glitch-free: it comes directly from a flop, not from combinational mux output.
- Illegal DATA_WIDTH is flagged by an elaboration-time assertion.

Test Plan:
1. Reset, DATA_WIDTH=8, PAR_EN=0, STOP2=0, send 0xA5 -> TX_OUT per cycle 0,1,0,1,0,0,1,0,1,1. BUSY high for 9 cycles, low in the stop cycle. Then idle stays 1.
2. PAR_EN=1, PAR_TYP=0, send 0xA5 -> parity bit 0 after data, frame 11 cycles. Repeat with PAR_TYP=1 -> parity bit 1. Send 0x01 with even parity -> parity bit 1.
3. STOP2=1, PAR_EN=1, send 0xFF -> 0, eight 1s, parity 0 (even), 1, 1. Frame 12 cycles, BUSY low only in the last stop cycle.
4. Back-to-back: hold DATA_VALID=1 with 0x3C then 0xC3 -> second start bit immediately follows first stop bit with no idle cycle. Both frames are bit-exact.
5. Change P_DATA and PAR_TYP and pulse DATA_VALID during frame 0x55 -> transmitted frame unchanged, extra request ignored, no second frame.
6. Assert RST low in the 4th data bit of 0x0F -> TX_OUT=1 and BUSY=0 asynchronously. After release with DATA_VALID=0 the line stays idle; a new 0x81 then transmits correctly.
